// File: rtl/dmem_access_unit.sv
// ----------------------------------------------------------------------------
// dmem_access_unit
//
// MEM-stage data-memory access unit. Each load or store presented by the
// pipeline becomes a single request on a wait-stated, word-addressed memory
// port. Stores get lane-replicated write data and byte enables, loads get
// their selected byte/half extracted and sign/zero-extended. The pipeline is
// stalled until the access completes, is rejected as misaligned, or times out.
//
// Parameters
//   ADDR_W       byte-address width (memory word address is ADDR_W-2 bits)
//   TIMEOUT_CYC  max ACCESS cycles waiting for mem_ack before error (>=1)
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   req_valid/we/dmtype/addr/wdata   request from the MEM stage
//   req_ready                 unit idle; request taken this cycle if req_valid
//   stall                     freeze IF..MEM pipeline registers
//   resp_valid/err/rdata      one-cycle completion pulse, error flag, load data
//   mem_en/be/addr/wdata      memory request (be=0000 means read)
//   mem_ack/rdata             memory completion and read word
// ----------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_dmtype,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int              CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Access-size decode; the unused codes 101-111 behave as word.
    function automatic logic is_half(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b010);
    endfunction

    function automatic logic is_byte(input logic [2:0] t);
        return (t == 3'b011) || (t == 3'b100);
    endfunction

    // Select the addressed byte/half of the read word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [2:0]  t,
                                                input logic [1:0]  lo);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? w[31:16] : w[15:0];
        case (t)
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {16'h0000, h};
            3'b011:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic [2:0]       lat_dmtype;
    logic [1:0]       lat_lo;

    logic             req_misaligned;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;

    // Request decode: alignment check and store lane formation.
    always_comb begin
        req_misaligned = 1'b0;
        st_be          = 4'b1111;
        st_wdata       = req_wdata;
        if (is_byte(req_dmtype)) begin
            st_be    = 4'b0001 << req_addr[1:0];
            st_wdata = {4{req_wdata[7:0]}};
        end else if (is_half(req_dmtype)) begin
            req_misaligned = req_addr[0];
            st_be          = req_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata       = {2{req_wdata[15:0]}};
        end else begin
            req_misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            lat_we     <= 1'b0;
            lat_dmtype <= 3'b000;
            lat_lo     <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_dmtype <= req_dmtype;
                        lat_lo     <= req_addr[1:0];
                        if (req_misaligned) begin
                            // Rejected without ever touching the memory port.
                            state      <= S_RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= S_ACCESS;
                            cnt       <= '0;
                            mem_en    <= 1'b1;
                            mem_be    <= req_we ? st_be : 4'b0000;
                            mem_addr  <= req_addr[ADDR_W-1:2];
                            mem_wdata <= req_we ? st_wdata : 32'h0;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack is tested first so an ack in the last counted cycle wins.
                    if (mem_ack) begin
                        state      <= S_RESP;
                        mem_en     <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_we ? 32'h0 : extend_load(mem_rdata, lat_dmtype, lat_lo);
                    end else if (cnt >= CNT_LAST) begin
                        state      <= S_RESP;
                        mem_en     <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    // Gated by rstn so a held req_valid cannot assert stall during reset.
    assign stall      = rstn & ((state == S_ACCESS) | ((state == S_IDLE) & req_valid));

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_dmtype = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, stall, resp_valid, resp_err, mem_en;
    logic [31:0] resp_rdata, mem_wdata;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    dmem_access_unit #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_we(req_we), .req_dmtype(req_dmtype),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          cycles;
    } memreq_t;

    resp_t   rq[$];
    memreq_t mq[$];

    int checks = 0;
    int errors = 0;

    int          plan_waits = 0;
    logic [31:0] plan_rdata = 32'h0;
    bit          resp_auto = 1'b1;
    bit          ignore_mem = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference rules written directly from the access-size semantics.
    function automatic int size_of(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] md, input logic [2:0] t, input int offs);
        int     bits;
        longint v;
        bits = 8 * size_of(t);
        v = (longint'(md) >> (8 * offs)) & ((64'd1 << bits) - 1);
        if ((t == 3'd1 || t == 3'd3) && v >= (64'd1 << (bits - 1)))
            v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] t);
        int sz;
        sz = size_of(t);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // Memory responder: acks after plan_waits wait cycles; random ack/data elsewhere.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (resp_auto) begin
                if (mem_en) begin
                    mem_ack   = (cyc == plan_waits);
                    mem_rdata = (cyc == plan_waits) ? plan_rdata : $urandom;
                    cyc++;
                end else begin
                    cyc       = 0;
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: pops expected responses and memory requests as the DUT presents them.
    initial begin
        bit      prev;
        int      run;
        memreq_t cur;
        resp_t   r;
        prev = 1'b0;
        run  = 0;
        forever begin
            @(negedge clk);
            if (rstn && !ignore_mem) begin
                if (mem_en && !prev) begin
                    if (mq.size() == 0) begin
                        chk("mem_en_unexpected", 32'd1, 32'd0);
                        cur = '{be: 4'h0, addr: 30'h0, wdata: 32'h0, cycles: 0};
                    end else begin
                        cur = mq.pop_front();
                        chk("mem_be", 32'(mem_be), 32'(cur.be));
                        chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
                        chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                    run = 1;
                end else if (mem_en && prev) begin
                    run++;
                    chk("mem_stable", {mem_be, 28'h0} ^ 32'(mem_addr) ^ mem_wdata,
                        {cur.be, 28'h0} ^ 32'(cur.addr) ^ cur.wdata);
                end else if (!mem_en && prev) begin
                    chk("mem_en_cycles", 32'(run), 32'(cur.cycles));
                end
                if (resp_valid) begin
                    if (rq.size() == 0) begin
                        chk("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        chk("resp_err", 32'(resp_err), 32'(r.err));
                        chk("resp_rdata", resp_rdata, r.rdata);
                    end
                end
            end
            prev = rstn && !ignore_mem && mem_en;
        end
    end

    // Issue one request, predict its outcome, and check latency/stall/pulse width.
    task automatic do_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] md, input int waits);
        int      sz, offs, acc, lat, st, w;
        bit      mis, tmo, done;
        resp_t   r;
        memreq_t m;
        sz   = size_of(t);
        offs = int'(a[1:0]);
        mis  = (offs % sz) != 0;
        acc  = (waits + 1 < TO) ? waits + 1 : TO;
        tmo  = !mis && (waits + 1 > TO);
        r.err   = mis || tmo;
        r.rdata = (r.err || we) ? 32'h0 : model_load(md, t, offs);
        if (!mis) begin
            m.be     = we ? 4'(((1 << sz) - 1) << offs) : 4'h0;
            m.addr   = a[31:2];
            m.wdata  = we ? model_wdata(d, t) : 32'h0;
            m.cycles = acc;
            mq.push_back(m);
        end
        rq.push_back(r);
        plan_waits = waits;
        plan_rdata = md;

        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_before_issue", 32'(req_ready), 32'd1);

        req_valid = 1'b1; req_we = we; req_dmtype = t; req_addr = a; req_wdata = d;
        #1;
        st = stall ? 1 : 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_dmtype = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        lat  = 0;
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (stall) st++;
            if (resp_valid) begin
                lat  = k;
                done = 1'b1;
            end
        end
        if (!done) chk("resp_timeout_bound", 32'd0, 32'd1);
        chk("resp_latency", 32'(lat), 32'(mis ? 1 : acc + 1));
        chk("stall_cycles", 32'(st), 32'(mis ? 1 : acc + 1));
        @(negedge clk);
        chk("resp_pulse_width", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  t;
        logic [31:0] a;
        // Reset state
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_outputs", {resp_err, 3'b0, mem_be, 24'h0} | resp_rdata | mem_wdata | 32'(mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Directed cases
        do_req(1'b1, 3'd3, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);       // sb
        do_req(1'b0, 3'd3, 32'h0000_1001, 32'h0, 32'h1234_F678, 0);       // lb
        do_req(1'b0, 3'd4, 32'h0000_1001, 32'h0, 32'h1234_F678, 1);       // lbu
        do_req(1'b0, 3'd1, 32'h0000_1002, 32'h0, 32'h8001_0000, 0);       // lh
        do_req(1'b0, 3'd2, 32'h0000_1002, 32'h0, 32'h8001_0000, 2);       // lhu
        do_req(1'b0, 3'd0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 3);       // lw, ack on last counted cycle
        do_req(1'b1, 3'd0, 32'h0000_1002, 32'h1111_2222, 32'h0, 0);       // sw misaligned
        do_req(1'b0, 3'd1, 32'h0000_2001, 32'h0, 32'h0, 0);               // lh misaligned
        do_req(1'b0, 3'd0, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 50);      // timeout
        do_req(1'b1, 3'd1, 32'h0000_3006, 32'h0000_BEEF, 32'h0, 1);       // sh upper half
        do_req(1'b0, 3'd7, 32'h0000_3004, 32'h0, 32'hC0DE_F00D, 0);       // 111 acts as word

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            t = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(t) - 1);
            do_req(1'($urandom_range(0, 1)), t, a, $urandom, $urandom, $urandom_range(0, 5));
        end

        // Reset in the middle of an access; a late ack afterwards must be ignored.
        resp_auto  = 1'b0;
        ignore_mem = 1'b1;
        mem_ack    = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'd0; req_addr = 32'h0000_2000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_mem_en", 32'(mem_en), 32'd1);
        #2;
        req_valid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rstn = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack_resp_valid", 32'(resp_valid), 32'd0);
            chk("late_ack_mem_en", 32'(mem_en), 32'd0);
            chk("late_ack_req_ready", 32'(req_ready), 32'd1);
        end
        mem_ack    = 1'b0;
        ignore_mem = 1'b0;
        resp_auto  = 1'b1;

        do_req(1'b0, 3'd4, 32'h0000_4003, 32'h0, 32'h8700_0000, 0);       // lbu after reset

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("mem_queue_empty", 32'(mq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
